led_pattern_sequencer: RTL

- Drives the board's four LEDs through four selectable display modes: off, blink-all, bouncing chase, and 4-bit binary count.
- Contains its own tick prescaler, a mode FSM advanced by a single-cycle request pulse, and a pause control.
- Sits between the debounced switch logic (upstream, supplies pulses and levels) and the LED pins (downstream).
- Generalises the fixed 1 Hz blinker into a sequenced, user-controlled display controller.

---
 rtl/led_pattern_sequencer_if.sv | 22 ++
 rtl/led_pattern_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Bus between the switch logic, the LED pattern sequencer and the LED pins.
// The master drives the mode pulse and pause level. The slave drives the LEDs and the status outputs.
interface led_pattern_sequencer_if;
  logic       i_Next_Mode;
  logic       i_Pause;
  logic       o_LED_1;
  logic       o_LED_2;
  logic       o_LED_3;
  logic       o_LED_4;
  logic [1:0] o_Mode;
  logic       o_Tick;

  modport master (
    output i_Next_Mode, i_Pause,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode, o_Tick
  );

  modport slave (
    input  i_Next_Mode, i_Pause,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode, o_Tick
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Four-LED display controller with four modes: off, blink, bouncing chase and binary count.
// It has its own step prescaler, a mode FSM advanced by a pulse, and a pause control.
module led_pattern_sequencer #(
  parameter int         TICK_CYCLES = 12_500_000,
  parameter logic [1:0] RESET_MODE  = 2'd1
) (
  input logic                     i_Clk,
  input logic                     i_Rst,
  led_pattern_sequencer_if.slave  bus
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  localparam logic [23:0] LAST_COUNT = 24'(TICK_CYCLES - 1);

  logic [1:0]  r_Mode;
  logic [3:0]  r_Step;
  logic [23:0] r_Count;
  logic        r_Tick;
  logic [3:0]  step_last;
  logic [3:0]  step_next;
  logic [3:0]  led_pattern;

  always_comb begin
    step_last = 4'd0;
    case (r_Mode)
      MODE_OFF:   step_last = 4'd0;
      MODE_BLINK: step_last = 4'd1;
      MODE_CHASE: step_last = 4'd5;
      MODE_COUNT: step_last = 4'd15;
      default:    step_last = 4'd0;
    endcase
    step_next = (r_Step == step_last) ? 4'd0 : r_Step + 4'd1;
  end

  // A mode pulse outranks everything else. A pending tick is then dropped and the step phase restarts.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Mode  <= RESET_MODE;
      r_Step  <= 4'd0;
      r_Count <= 24'd0;
      r_Tick  <= 1'b0;
    end else if (bus.i_Next_Mode) begin
      r_Mode  <= r_Mode + 2'd1;
      r_Step  <= 4'd0;
      r_Count <= 24'd0;
      r_Tick  <= 1'b0;
    end else if (bus.i_Pause) begin
      r_Tick  <= 1'b0;
    end else begin
      if (r_Tick) begin
        r_Step <= step_next;
      end
      if (r_Count == LAST_COUNT) begin
        r_Count <= 24'd0;
        r_Tick  <= 1'b1;
      end else begin
        r_Count <= r_Count + 24'd1;
        r_Tick  <= 1'b0;
      end
    end
  end

  // Pattern bit 3 drives LED 1 and bit 0 drives LED 4.
  always_comb begin
    led_pattern = 4'b0000;
    case (r_Mode)
      MODE_OFF:   led_pattern = 4'b0000;
      MODE_BLINK: led_pattern = {4{r_Step[0]}};
      MODE_CHASE: begin
        case (r_Step)
          4'd0:    led_pattern = 4'b1000;
          4'd1:    led_pattern = 4'b0100;
          4'd2:    led_pattern = 4'b0010;
          4'd3:    led_pattern = 4'b0001;
          4'd4:    led_pattern = 4'b0010;
          4'd5:    led_pattern = 4'b0100;
          default: led_pattern = 4'b0000;
        endcase
      end
      MODE_COUNT: led_pattern = r_Step;
      default:    led_pattern = 4'b0000;
    endcase
  end

  assign bus.o_LED_1 = led_pattern[3];
  assign bus.o_LED_2 = led_pattern[2];
  assign bus.o_LED_3 = led_pattern[1];
  assign bus.o_LED_4 = led_pattern[0];
  assign bus.o_Mode  = r_Mode;
  assign bus.o_Tick  = r_Tick;

endmodule
